// File: rtl/div_pkg.sv
// Purpose: shared constants and FSM state encoding for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH = 64;
    // Wide enough to count DIV_WIDTH-1 down to 0.
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_nbit.sv
// Purpose: N-bit carry adder (sum = a + b + cin) with carry-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i (N bits) operands; cin_i carry-in; sum_o (N bits) sum; cout_o carry-out.
module cla_nbit #(
    parameter int N = 65
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    always_comb begin
        carry    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum_o  = prop ^ carry[N-1:0];
    assign cout_o = carry[N];

endmodule

// File: rtl/iter_64bit_div.sv
// Purpose: unsigned radix-2 restoring divider, one quotient bit per cycle.
// Latency: result valid WIDTH+1 cycles after accept; 1 cycle for divide-by-zero
//          (and for dividend<divisor when DIV_EARLY_OUT_EN is defined).
// Backpressure: single outstanding op; in_ready only in IDLE, result held until out_ready.
// Ports: clk/rst (async active-high); in_valid/in_ready + dividend/divisor operand handshake;
//        out_valid/out_ready + quotient/remainder/div_by_zero result handshake.
// Optional macro: DIV_EARLY_OUT_EN -- skips CALC when dividend < divisor.
module iter_64bit_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    // quo_q starts as the dividend and shifts quotient bits in from the right.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     sub_b;
    logic [WIDTH:0]     diff;
    logic               no_borrow;
    logic [WIDTH:0]     restored;
    logic               unused_rem_msb;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign sub_b   = ~{1'b0, dvs_q};

    // shifted - divisor; carry-out set means the difference is non-negative.
    cla_nbit #(.N(WIDTH + 1)) u_sub (
        .a_i    (shifted),
        .b_i    (sub_b),
        .cin_i  (1'b1),
        .sum_o  (diff),
        .cout_o (no_borrow)
    );

    assign restored = no_borrow ? diff : shifted;
    // The kept remainder is always below the divisor, so its top bit is zero.
    assign unused_rem_msb = restored[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (dividend < divisor) begin
                        quo_d   = '0;
                        rem_d   = dividend;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        quo_d   = dividend;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = restored[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_64bit_div.sv
// Purpose: directed vector bench for iter_64bit_div (results, latency, hold, reset).
// Latency: n/a.
// Backpressure: exercises out_ready held low and operand changes while busy.
module tb_iter_64bit_div;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    iter_64bit_div #(.WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (a < b) return 1;
`endif
        return 65;
    endfunction

    // Presents operands in cycle T; returns #1 after the accepting edge (cycle T+1).
    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        check("in_ready before accept", {63'd0, in_ready}, 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    // Counts cycles from T; bounded so a stuck DUT shows up as a latency failure.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid after handshake", {63'd0, out_valid}, 64'd0);
        check("in_ready after handshake", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        logic saw_valid;

        vecs[0]  = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
        vecs[1]  = '{ONES, 64'd1, ONES, 64'd0, 1'b0};
        vecs[2]  = '{ONES, ONES, 64'd1, 64'd0, 1'b0};
        vecs[3]  = '{64'd123, 64'd0, ONES, 64'd123, 1'b1};
        vecs[4]  = '{64'd5, 64'd9, 64'd0, 64'd5, 1'b0};
        vecs[5]  = '{64'd1000, 64'd10, 64'd100, 64'd0, 1'b0};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0};
        vecs[7]  = '{64'hDEAD_BEEF_0000_0000, 64'h1_0000_0000, 64'hDEAD_BEEF, 64'd0, 1'b0};
        vecs[8]  = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0};
        vecs[9]  = '{64'd12345, 64'd12345, 64'd1, 64'd0, 1'b0};
        vecs[10] = '{ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};

        // Reset state.
        #12;
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst quotient", quotient, 64'd0);
        check("rst remainder", remainder, 64'd0);
        check("rst div_by_zero", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", {63'd0, in_ready}, 64'd1);

        // Table of directed vectors.
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(exp_lat(vecs[i].a, vecs[i].b)));
            check($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d div_by_zero", i), {63'd0, div_by_zero}, {63'd0, vecs[i].z});
            handshake();
        end

        // Backpressure: result held for 10 cycles while inputs wiggle.
        start_op(64'd100, 64'd7);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'd65);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 64'd55 + 64'(i);
            divisor  = 64'd0;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp%0d in_ready", i), {63'd0, in_ready}, 64'd0);
            check($sformatf("bp%0d quotient", i), quotient, 64'd14);
            check($sformatf("bp%0d remainder", i), remainder, 64'd2);
            check($sformatf("bp%0d div_by_zero", i), {63'd0, div_by_zero}, 64'd0);
        end
        // in_valid stays high across the handshake edge: it must not be taken in DONE.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp no accept in DONE", {63'd0, out_valid}, 64'd0);
        check("bp in_ready after hs", {63'd0, in_ready}, 64'd1);

        // Reset mid-calculation at T+30.
        start_op(64'd100, 64'd7);
        repeat (29) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midrst out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst quotient", quotient, 64'd0);
        check("midrst remainder", remainder, 64'd0);
        check("midrst div_by_zero", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst in_ready", {63'd0, in_ready}, 64'd1);
        saw_valid = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst no stale result", {63'd0, saw_valid}, 64'd0);
        start_op(64'd100, 64'd7);
        wait_valid(lat);
        check("after rst latency", 64'(lat), 64'd65);
        check("after rst quotient", quotient, 64'd14);
        check("after rst remainder", remainder, 64'd2);
        check("after rst div_by_zero", {63'd0, div_by_zero}, 64'd0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
